ipf_acc: RTL and testbench
==========================

IPF_ACC -- requirements
Module: ipf_acc

Interface
REQ-001 Parameter LANES, default 8: number of CUBE lanes consumed per beat.
REQ-002 Parameter PROD_W, default 16: width of one product.
REQ-003 Parameter ACC_W, default 24, legal range 20..32: width of each lane accumulator and output word.
REQ-004 Port clk, input, 1: the block's single clock, rising-edge active.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port res, input, LANES*9*PROD_W (1152): lane k occupies bits [144k+143:144k]; 9 unsigned products per lane.
REQ-007 Port res_valid, input, 1: res carries a valid pass beat.
REQ-008 Port in_ready, output, 1: the block accepts the beat this cycle.
REQ-009 Port wsize, input, 2: window size, 0=3x3, 1=5x5, 2=7x7, 3=reserved; sampled only on the first beat of a group.
REQ-010 Port out_data, output, LANES*ACC_W: lane k occupies bits [ACC_W*(k+1)-1:ACC_W*k].
REQ-011 Port out_valid, output, 1: out_data holds a finished window sum.
REQ-012 Port out_ready, input, 1: the consumer takes out_data this cycle.
REQ-013 Port err, output, 1: sticky error flag.

Function
REQ-014 A beat is accepted when res_valid && in_ready are both high at a clk edge; a beat with res_valid low or in_ready low has no effect.
REQ-015 Stage 1 registers, per lane, the unsigned sum of the 9 products (20 bits, zero-extended to ACC_W) together with a final-pass tag, 1 cycle after acceptance.
REQ-016 A group is the number of passes that make up one window: 1 pass for wsize 0, 3 for wsize 1, 6 for wsize 2.
REQ-017 wsize 3 is treated as a 1-pass group and sets err.
REQ-018 FSM state IDLE: no partial sum is held; an accepted beat latches the group length from wsize, clears pass_cnt, and moves to ACC (or stays in IDLE if the group is 1 pass).
REQ-019 FSM state ACC: each accepted beat increments pass_cnt; the beat that makes pass_cnt equal the group length minus 1 is tagged final and the FSM returns to IDLE.
REQ-020 Stage 2 (accumulate): on the first pass of a group the accumulator is loaded with the stage-1 sum; on later passes the stage-1 sum is added to the accumulator.
REQ-021 On a final pass, the accumulated value (including that pass) is pushed into a 2-entry output FIFO instead of being kept in the accumulator.
REQ-022 Latency: for a 1-pass group accepted at cycle N, out_valid rises at cycle N+2 when the FIFO was empty.
REQ-023 out_data is the FIFO head; it is held stable while out_valid && !out_ready; the entry is popped on out_valid && out_ready.
REQ-024 in_ready is low when the FIFO holds 2 entries, or when it holds 1 entry and stage 1 holds a final-tagged beat; otherwise in_ready is high.
REQ-025 A FIFO push and pop in the same cycle leave the count unchanged, with the entry order preserved.
REQ-026 An accumulator result exceeding ACC_W bits sets err; the stored value is then governed by REQ-031/REQ-032.
REQ-027 err is sticky and is cleared only by rst.

Reset
REQ-028 When rst is high at a clk edge, the following are cleared: FSM to IDLE, pass_cnt=0, all accumulators=0, stage-1 valid=0, FIFO count=0, out_valid=0, out_data=0, err=0, in_ready=1 on the first cycle after reset.
REQ-029 Reset asserted mid-group discards the partial sum and all FIFO contents; no output beat is produced for that group.
REQ-030 rst has priority over any simultaneous accept or pop.

Configuration
REQ-031 With macro IPF_ACC_SAT_EN defined, an overflowing accumulation clamps to 2^ACC_W-1 for the rest of the group.
REQ-032 Without IPF_ACC_SAT_EN, an overflowing accumulation wraps modulo 2^ACC_W; err is set in both builds.

Verification
REQ-033 wsize=0, one beat with all products in lane 0 equal to 1 and lane 7 equal to 0xFFFF -> out_valid 2 cycles later; lane0=9, lane7=589815 (0x8FFF7), err=0.
REQ-034 wsize=2, six beats with all products equal to 2 -> exactly one output after the 6th beat; every lane equals 108; no out_valid after beats 1..5.
REQ-035 out_ready held low, three consecutive wsize=0 beats -> in_ready drops after the 2nd final beat enters stage 1; FIFO holds 2 entries; raising out_ready pops them in order, and the 3rd beat is accepted afterwards.
REQ-036 ACC_W=20, wsize=2, all products 0xFFFF -> err=1; the lane value equals 0xFFFFF with IPF_ACC_SAT_EN defined, and (6*589815) mod 2^20 without it.
REQ-037 rst pulsed after the 2nd beat of a wsize=1 group, then a fresh 3-beat group of 1s -> outputs equal 27 only, no stale sum, err=0.
REQ-038 wsize=3, single beat -> output produced after 1 pass, err=1 and err remains 1 until rst.

Source files
------------

// File: rtl/ipf_acc.sv
// Per-lane window accumulator: sums 9 products per lane per beat, accumulates 1/3/6
// passes per window and queues finished sums in a 2-entry output FIFO. Saturating build: IPF_ACC_SAT_EN.
module ipf_acc #(
  parameter int LANES  = 8,
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES*9*PROD_W-1:0] res,
  input  logic                     res_valid,
  output logic                     in_ready,
  input  logic [1:0]               wsize,
  output logic [LANES*ACC_W-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err,
  output logic                     o_dbg_state
);

  localparam int SUM_W = PROD_W + 4;

  // Handshake: a beat moves on res when res_valid && in_ready at a rising clk edge;
  // a FIFO entry leaves when out_valid && out_ready at a rising clk edge.
  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [2:0]             r_glen, w_glen_nxt;
  logic [2:0]             r_pass_cnt, w_cnt_nxt;
  logic [2:0]             w_ws_len;
  logic                   w_accept, w_final, w_first, w_ws_err;

  logic [SUM_W-1:0]       w_lane_sum [LANES];
  logic [ACC_W-1:0]       r_s1_sum   [LANES];
  logic                   r_s1_valid, r_s1_final, r_s1_first;

  logic [ACC_W-1:0]       r_acc      [LANES];
  logic [ACC_W:0]         w_acc_sum  [LANES];
  logic [ACC_W-1:0]       w_acc_res  [LANES];
  logic                   w_ovf;
  logic [LANES*ACC_W-1:0] w_push_data;

  logic [LANES*ACC_W-1:0] r_mem [2];
  logic                   r_wr_ptr, r_rd_ptr;
  logic [1:0]             r_cnt;
  logic                   w_push, w_pop;
  logic                   r_err;

  assign w_accept    = res_valid && in_ready;
  assign in_ready    = !((r_cnt == 2'd2) || ((r_cnt == 2'd1) && r_s1_valid && r_s1_final));
  assign out_valid   = (r_cnt != 2'd0);
  assign out_data    = r_mem[r_rd_ptr];
  assign err         = r_err;
  assign o_dbg_state = r_state;
  assign w_push      = r_s1_valid && r_s1_final;
  assign w_pop       = out_valid && out_ready;

  always_comb begin
    case (wsize)
      2'd1:    w_ws_len = 3'd3;
      2'd2:    w_ws_len = 3'd6;
      default: w_ws_len = 3'd1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_glen_nxt  = r_glen;
    w_cnt_nxt   = r_pass_cnt;
    w_final     = 1'b0;
    w_first     = 1'b0;
    w_ws_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_glen_nxt  = w_ws_len;
          w_cnt_nxt   = 3'd0;
          w_first     = 1'b1;
          w_final     = (w_ws_len == 3'd1);
          w_ws_err    = (wsize == 2'd3);
          w_state_nxt = (w_ws_len == 3'd1) ? S_IDLE : S_ACC;
        end
      end
      S_ACC: begin
        if (w_accept) begin
          w_cnt_nxt = r_pass_cnt + 3'd1;
          w_final   = ((r_pass_cnt + 3'd1) == (r_glen - 3'd1));
          if (w_final) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_glen     <= 3'd1;
      r_pass_cnt <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_glen     <= w_glen_nxt;
      r_pass_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_lane_sum[k] = '0;
      for (int j = 0; j < 9; j++)
        w_lane_sum[k] = w_lane_sum[k] + SUM_W'(res[(k*9+j)*PROD_W +: PROD_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_final <= 1'b0;
      r_s1_first <= 1'b0;
      for (int k = 0; k < LANES; k++) r_s1_sum[k] <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_final <= w_final;
        r_s1_first <= w_first;
        for (int k = 0; k < LANES; k++) r_s1_sum[k] <= ACC_W'(w_lane_sum[k]);
      end
    end
  end

  // The carry out of each lane add flags overflow; once clamped, further adds keep clamping.
  always_comb begin
    w_ovf       = 1'b0;
    w_push_data = '0;
    for (int k = 0; k < LANES; k++) begin
      w_acc_sum[k] = {1'b0, (r_s1_first ? {ACC_W{1'b0}} : r_acc[k])} + {1'b0, r_s1_sum[k]};
      w_ovf        = w_ovf | w_acc_sum[k][ACC_W];
`ifdef IPF_ACC_SAT_EN
      w_acc_res[k] = w_acc_sum[k][ACC_W] ? {ACC_W{1'b1}} : w_acc_sum[k][ACC_W-1:0];
`else
      w_acc_res[k] = w_acc_sum[k][ACC_W-1:0];
`endif
      w_push_data[k*ACC_W +: ACC_W] = w_acc_res[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
    end else if (r_s1_valid) begin
      for (int k = 0; k < LANES; k++) r_acc[k] <= r_s1_final ? {ACC_W{1'b0}} : w_acc_res[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 2'd1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | w_ws_err | (r_s1_valid && w_ovf);
  end

endmodule

// File: tb/tb_ipf_acc.sv
// Bench for ipf_acc: a window-sum model checks every popped output of a 24-bit and a 20-bit instance.
module tb_ipf_acc;
  localparam int LANES = 8;
  localparam int PW    = 16;
  localparam int RW    = LANES*9*PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] res = '0;
  logic          res_valid = 1'b0;
  logic [1:0]    wsize = 2'd0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, err, dbg;
  logic [LANES*24-1:0] out_data;
  logic          in_ready2, out_valid2, err2, dbg2;
  logic [LANES*20-1:0] out_data2;

  ipf_acc #(.LANES(LANES), .PROD_W(PW), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .res(res), .res_valid(res_valid), .in_ready(in_ready),
    .wsize(wsize), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .o_dbg_state(dbg));

  ipf_acc #(.LANES(LANES), .PROD_W(PW), .ACC_W(20)) dut20 (
    .clk(clk), .rst(rst), .res(res), .res_valid(res_valid), .in_ready(in_ready2),
    .wsize(wsize), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .err(err2), .o_dbg_state(dbg2));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  bit rnd_phase = 1'b0;

  logic [LANES*24-1:0] exp_q[$];
  logic [LANES*20-1:0] exp20_q[$];
  logic [LANES*24-1:0] last24 = '0;
  logic [LANES*20-1:0] last20 = '0;

  int     m_glen = 1;
  int     m_cnt  = 0;
  longint m_tot [LANES];
  longint m_s24 [LANES];
  longint m_s20 [LANES];
  bit     m_err24 = 1'b0;
  bit     m_err20 = 1'b0;

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic longint lane_sum(input logic [RW-1:0] r, input int k);
    longint s = 0;
    for (int j = 0; j < 9; j++) s += longint'(r[(k*9+j)*PW +: PW]);
    return s;
  endfunction

  function automatic longint clamp(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Window model: group length from the first beat, plain integer sums, then saturate or wrap.
  task automatic model_accept(input logic [1:0] ws, input logic [RW-1:0] r);
    logic [LANES*24-1:0] e24;
    logic [LANES*20-1:0] e20;
    longint s;
    if (m_cnt == 0) begin
      m_glen = (ws == 2'd1) ? 3 : (ws == 2'd2) ? 6 : 1;
      if (ws == 2'd3) begin m_err24 = 1'b1; m_err20 = 1'b1; end
      for (int k = 0; k < LANES; k++) begin m_tot[k] = 0; m_s24[k] = 0; m_s20[k] = 0; end
    end
    for (int k = 0; k < LANES; k++) begin
      s = lane_sum(r, k);
      m_tot[k] += s;
      m_s24[k] = clamp(m_s24[k] + s, 64'd16777215);
      m_s20[k] = clamp(m_s20[k] + s, 64'd1048575);
      if (m_tot[k] > 64'd16777215) m_err24 = 1'b1;
      if (m_tot[k] > 64'd1048575)  m_err20 = 1'b1;
    end
    m_cnt++;
    if (m_cnt == m_glen) begin
      for (int k = 0; k < LANES; k++) begin
`ifdef IPF_ACC_SAT_EN
        e24[k*24 +: 24] = 24'(m_s24[k]);
        e20[k*20 +: 20] = 20'(m_s20[k]);
`else
        e24[k*24 +: 24] = 24'(m_tot[k]);
        e20[k*20 +: 20] = 20'(m_tot[k]);
`endif
      end
      exp_q.push_back(e24);
      exp20_q.push_back(e20);
      m_cnt = 0;
    end
  endtask

  // Compare process: every pop is checked against the model; stalled outputs must hold.
  initial begin
    bit stalled = 1'b0;
    logic [LANES*24-1:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp20_q.delete();
        m_cnt   = 0;
        m_err24 = 1'b0;
        m_err20 = 1'b0;
        stalled = 1'b0;
      end else begin
        if (stalled && out_valid) chk("hold", out_data, held);
        stalled = out_valid && !out_ready;
        held    = out_data;
        if (out_valid && out_ready) begin
          n_out++;
          last24 = out_data;
          if (exp_q.size() == 0) chk("unexpected_out24", 1, 0);
          else chk("out24", out_data, exp_q.pop_front());
        end
        if (out_valid2 && out_ready) begin
          last20 = out_data2;
          if (exp20_q.size() == 0) chk("unexpected_out20", 1, 0);
          else chk("out20", out_data2, exp20_q.pop_front());
        end
        if (res_valid && in_ready) model_accept(wsize, res);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_phase) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] ws, input logic [RW-1:0] r);
    wsize = ws;
    res = r;
    res_valid = 1'b1;
  endtask

  task automatic wait_acc();
    bit a = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      if (a) break;
    end
    if (!a) chk("accept_timeout", 0, 1);
    res_valid = 1'b0;
  endtask

  task automatic drive(input logic [1:0] ws, input logic [RW-1:0] r);
    put(ws, r);
    wait_acc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  function automatic logic [RW-1:0] fill(input logic [15:0] v);
    logic [RW-1:0] r;
    for (int j = 0; j < LANES*9; j++) r[j*PW +: PW] = v;
    return r;
  endfunction

  function automatic logic [RW-1:0] rnd_res();
    logic [RW-1:0] r;
    for (int j = 0; j < LANES*9; j++) r[j*PW +: PW] = 16'($urandom);
    return r;
  endfunction

  initial begin
    logic [RW-1:0] r;
    int n0;
    logic [1:0] ws;

    idle(1);
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);

    // Single 3x3 beat: lane 0 all ones, lane 7 all 0xFFFF.
    r = '0;
    for (int j = 0; j < 9; j++) begin
      r[j*PW +: PW] = 16'd1;
      r[(7*9+j)*PW +: PW] = 16'hFFFF;
    end
    drive(2'd0, r);
    chk("lat_n1_valid", out_valid, 0);
    idle(1);
    chk("lat_n2_valid", out_valid, 1);
    chk("lit_lane0_9", out_data[0 +: 24], 24'd9);
    chk("lit_lane7", out_data[7*24 +: 24], 24'd589815);
    idle(3);
    chk("lit_err0", err, 0);

    // 7x7 group of twos.
    n0 = n_out;
    for (int b = 0; b < 5; b++) drive(2'd2, fill(16'd2));
    idle(3);
    chk("w7_no_early_out", n_out, n0);
    chk("w7_valid_low", out_valid, 0);
    drive(2'd2, fill(16'd2));
    idle(3);
    chk("w7_one_out", n_out, n0 + 1);
    chk("w7_lane0_108", last24[0 +: 24], 24'd108);
    chk("w7_lane7_108", last24[7*24 +: 24], 24'd108);

    // Back-pressure with out_ready low.
    out_ready = 1'b0;
    drive(2'd0, fill(16'd1));
    drive(2'd0, fill(16'd2));
    chk("bp_ready_low", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    put(2'd0, fill(16'd3));
    idle(2);
    chk("bp_ready_low_full", in_ready, 0);
    chk("bp_head_9", out_data[0 +: 24], 24'd9);
    out_ready = 1'b1;
    wait_acc();
    idle(5);
    chk("bp_third_27", last24[0 +: 24], 24'd27);

    // Overflow: only the 20-bit instance overflows.
    drive(2'd2, fill(16'hFFFF));
    for (int b = 0; b < 5; b++) drive(2'd2, fill(16'hFFFF));
    idle(4);
    chk("ovf_err20", err2, 1);
    chk("ovf_err24_clear", err, 0);
    chk("ovf_lane24", last24[0 +: 24], 24'd3538890);
`ifdef IPF_ACC_SAT_EN
    chk("ovf_lane20_sat", last20[0 +: 20], 20'hFFFFF);
`else
    chk("ovf_lane20_wrap", last20[0 +: 20], 20'd393162);
`endif
    do_reset();
    chk("ovf_err20_reset", err2, 0);

    // Reset mid-group discards the partial sum.
    drive(2'd1, rnd_res());
    drive(2'd1, rnd_res());
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n0 = n_out;
    for (int b = 0; b < 3; b++) drive(2'd1, fill(16'd1));
    idle(4);
    chk("rst_mid_one_out", n_out, n0 + 1);
    chk("rst_mid_lane0_27", last24[0 +: 24], 24'd27);
    chk("rst_mid_lane3_27", last24[3*24 +: 24], 24'd27);
    chk("rst_mid_err0", err, 0);

    // Reserved wsize behaves as 1 pass and sets a sticky error.
    n0 = n_out;
    drive(2'd3, fill(16'd1));
    idle(4);
    chk("ws3_one_out", n_out, n0 + 1);
    chk("ws3_lane0_9", last24[0 +: 24], 24'd9);
    chk("ws3_err", err, 1);
    drive(2'd0, fill(16'd4));
    drive(2'd1, fill(16'd4));
    idle(4);
    chk("ws3_err_sticky", err, 1);
    do_reset();
    chk("ws3_err_cleared", err, 0);

    // Randomized traffic with random back-pressure.
    rnd_phase = 1'b1;
    for (int b = 0; b < 300; b++) begin
      ws = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      drive(ws, rnd_res());
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    rnd_phase = 1'b0;
    out_ready = 1'b1;
    idle(20);
    chk("rnd_drained24", exp_q.size(), 0);
    chk("rnd_drained20", exp20_q.size(), 0);
    chk("rnd_err24", err, m_err24);
    chk("rnd_err20", err2, m_err20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
